spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- SPI mode-0 initiator that streams bytes out of the external QSPI-capable flash using the single-lane READ (0x03) command.
- Used by the jacaranda-8 user project to load its instruction/data memory from the same flash part the Caravel spiflash model provides.
- Drives csb/clk/io0 and samples io1.
- Delivers bytes over a valid/ready stream with full backpressure; backpressure stalls SCK.

Parameters:
- CLK_DIV, 2, SCK half-period in wb_clk_i cycles; must be >= 1.
- LEN_WIDTH, 16, width of the byte-count input.
- CS_IDLE, 4, minimum wb_clk_i cycles flash_csb stays high between transfers.

Ports:
- wb_clk_i  input  1  system clock.
- wb_rst_i  input  1  synchronous active-high reset.
- start  input  1  one-cycle request, honoured only in IDLE.
- addr  input  24  flash byte address, captured on start.
- len  input  LEN_WIDTH  number of bytes to read, captured on start.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse at end of transfer.
- data_o  output  8  read byte.
- data_valid  output  1  data_o holds an unconsumed byte.
- data_ready  input  1  consumer accepts data_o when valid&ready.
- flash_csb  output  1  chip select, active low.
- flash_clk  output  1  SCK, idles low.
- flash_io0  output  1  MOSI.
- flash_io1  input  1  MISO.

Behaviour:
- Reset values (next edge after wb_rst_i high, from any state): flash_csb=1, flash_clk=0, flash_io0=0, busy=0, done=0, data_valid=0, data_o=0, state=IDLE. Reset mid-transfer aborts immediately; no partial byte is emitted.
- States and transitions:
  - IDLE: start with len!=0 -> CMD. Latch addr, len; csb=0; io0 = bit7 of 0x03; busy=1.
  - IDLE: start with len==0 -> DONE directly. csb is never asserted.
  - CMD: 8 bits, MSB first -> ADDR.
  - ADDR: 24 bits, MSB first -> DATA.
  - DATA: shift in bytes until len bytes have been delivered -> CSWAIT.
  - CSWAIT: csb=1, hold CS_IDLE cycles -> DONE.
  - DONE: done=1, busy=0 for one cycle -> IDLE.
- start is ignored while busy=1.
- SCK generation: a divider counter toggles flash_clk every CLK_DIV cycles.
  - First rising edge occurs CLK_DIV cycles after csb falls.
  - MOSI changes only on falling-edge ticks, or on csb fall for bit 0.
  - MISO is sampled into the shift register on rising-edge ticks.
- Framing:
  - 32 SCK rising edges cover command plus address.
  - io0 is driven 0 during DATA.
  - The first data bit is sampled on the 33rd rising edge.
- Byte hand-off: after the 8th sampled bit, the byte moves to data_o on the next cycle.
  - data_valid rises one cycle after the 8th rising edge.
  - If data_valid=1 and data_ready=0 at that moment, the byte waits in the shift register.
- Stall rule: SCK is held low, before the next rising edge, while a completed byte waits in the shift register. The divider is frozen. Stall length is unbounded; no bit may be lost or duplicated.
- Simultaneous accept and new byte: if data_valid&data_ready in the same cycle a byte completes, data_o is loaded with the new byte and data_valid stays 1.
- Completion: the remaining-byte counter decrements on each shift-to-output transfer.
  - After the last byte is sampled, SCK stops low and csb rises at once. No extra edges are issued.
  - CSWAIT is not entered until the last byte has been accepted, i.e. data_valid falls.
- Address is not incremented internally; the flash auto-increments. Wrap beyond 0xFFFFFF follows flash behaviour.

Decomposition:
- Shared package/include: state encoding (IDLE, CMD, ADDR, DATA, CSWAIT, DONE), CMD_READ = 8'h03, ADDR_BITS = 24.
- One sub-module, spi_sck_gen. Holds the CLK_DIV counter and a freeze input, and outputs flash_clk, rise_tick and fall_tick.
- The FSM, shift registers and counters stay in spi_flash_reader.

Test Plan:
- Basic read: start, addr=0x000000, len=4, data_ready=1, CLK_DIV=2, against the spiflash model loaded with jacaranda_test.hex.
  - io0 shows 0x03,0x00,0x00,0x00 over 32 rising edges.
  - 4 data_valid beats equal to hex bytes 0..3.
  - One done pulse; csb high for >= 4 cycles.
- Timing: CLK_DIV=2.
  - SCK period is 4 cycles; first rise 2 cycles after csb falls.
  - data_valid for byte 0 rises 1 cycle after the 40th rising edge.
- Backpressure: addr=0x000100, len=3; data_ready=0 for 50 cycles after the first valid.
  - SCK is frozen low and csb stays low.
  - Bytes 0x100..0x102 are delivered in order, none lost or duplicated.
- Zero length: start with len=0.
  - done pulses 2 cycles after start; csb never low; data_valid never high.
- Reset mid-ADDR: assert wb_rst_i for 1 cycle after the 12th rising edge.
  - Next cycle csb=1, flash_clk=0, busy=0, data_valid=0.
  - A following start with addr=0x000000, len=1 returns hex byte 0.
- Busy start: issue a start with addr=0x000200 while busy=1.
  - It is ignored; only the first transfer's bytes appear and only one done pulse occurs.

Source files
------------

// File: rtl/spi_flash_reader_pkg.sv
// Shared definitions for the SPI flash reader: FSM state encoding and the
// fixed framing of a single-lane READ transaction.
package spi_flash_reader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DATA,
      CSWAIT,
      DONE
   } state_e;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam int         ADDR_BITS = 24;
   // Command byte plus address, shifted out as one 32-bit word.
   localparam int         HDR_BITS  = 8 + ADDR_BITS;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 serial clock generator.
// Toggles sck_o every CLK_DIV cycles while en_i is high and reports the edge it
// is about to make through single-cycle tick strobes.
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   en_i        run; when low, sck_o returns low and the divider restarts
//   freeze_i    hold sck_o low (divider frozen) before the next rising edge
//   sck_o       serial clock, idles low
//   rise_tick_o sck_o goes high at the coming clk_i edge
//   fall_tick_o sck_o goes low at the coming clk_i edge
module spi_sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic freeze_i,
   output logic sck_o,
   output logic rise_tick_o,
   output logic fall_tick_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sck_q, sck_d;
   logic          hold;
   logic          tick;

   // Freezing only bites while SCK is low, so a high phase always completes
   // and the stall lands before the next rising edge.
   assign hold = freeze_i && !sck_q;
   assign tick = en_i && !hold && (cnt_q == CW'(CLK_DIV - 1));

   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      sck_d = sck_q;
      if (!en_i) begin
         cnt_d = '0;
         sck_d = 1'b0;
      end else if (!hold) begin
         if (tick) begin
            cnt_d = '0;
            sck_d = !sck_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   end

   assign sck_o       = sck_q;
   assign rise_tick_o = tick && !sck_q;
   assign fall_tick_o = tick && sck_q;

endmodule

// File: rtl/spi_flash_reader.sv
// SPI mode-0 initiator that streams bytes from a serial flash with the
// single-lane READ (0x03) command and hands them over a valid/ready stream.
// Backpressure stalls SCK low, so no byte is ever dropped.
//   wb_clk_i / wb_rst_i        system clock, synchronous active-high reset
//   start, addr, len           transfer request (honoured only when idle)
//   busy, done                 transfer in progress / one-cycle end pulse
//   data_o, data_valid,
//   data_ready                 output byte stream
//   flash_csb, flash_clk,
//   flash_io0, flash_io1       SPI pins (CS#, SCK, MOSI, MISO)
module spi_flash_reader
   import spi_flash_reader_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int LEN_WIDTH = 16,
   parameter int CS_IDLE   = 4
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 start,
   input  logic [23:0]          addr,
   input  logic [LEN_WIDTH-1:0] len,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           data_o,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 flash_csb,
   output logic                 flash_clk,
   output logic                 flash_io0,
   input  logic                 flash_io1
);

   localparam int CSW = $clog2(CS_IDLE + 1);

   state_e               state_q, state_d;
   logic [HDR_BITS-1:0]  tx_q, tx_d;
   logic [5:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           rx_q, rx_d;
   logic [3:0]           rx_cnt_q, rx_cnt_d;
   logic [LEN_WIDTH-1:0] rem_q, rem_d;
   logic [7:0]           data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 csb_q, csb_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [CSW-1:0]       cs_cnt_q, cs_cnt_d;

   logic sck, rise_tick, fall_tick;
   logic byte_full, last_full, sck_en;

   // A byte sitting complete in rx_q holds SCK low until it can move out.
   assign byte_full = (rx_cnt_q == 4'd8);
   assign last_full = byte_full && (rem_q == LEN_WIDTH'(1));
   // Once the last byte is in, SCK parks low in the same edge that raises csb.
   assign sck_en    = (state_q inside {CMD, ADDR, DATA}) && !csb_q && !last_full;

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk_i       (wb_clk_i),
      .rst_i       (wb_rst_i),
      .en_i        (sck_en),
      .freeze_i    (byte_full),
      .sck_o       (sck),
      .rise_tick_o (rise_tick),
      .fall_tick_o (fall_tick)
   );

   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      bit_cnt_d = bit_cnt_q;
      rx_d      = rx_q;
      rx_cnt_d  = rx_cnt_q;
      rem_d     = rem_q;
      data_d    = data_q;
      valid_d   = valid_q;
      csb_d     = csb_q;
      busy_d    = busy_q;
      done_d    = (state_q == DONE);
      cs_cnt_d  = cs_cnt_q;

      // MOSI advances on falling edges; zeros fill in behind, so io0 is
      // already low when the data phase begins.
      if (fall_tick) begin
         tx_d = {tx_q[HDR_BITS-2:0], 1'b0};
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               if (len != '0) begin
                  state_d   = CMD;
                  tx_d      = {CMD_READ, addr};
                  rem_d     = len;
                  bit_cnt_d = '0;
                  rx_cnt_d  = '0;
                  csb_d     = 1'b0;
               end else begin
                  state_d = DONE;
               end
            end
         end
         CMD: begin
            if (rise_tick) begin
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == 6'd7) begin
                  state_d = ADDR;
               end
            end
         end
         ADDR: begin
            if (rise_tick) begin
               bit_cnt_d = bit_cnt_q + 6'd1;
            end
            // Switch after the falling edge that follows the 32nd rise, so the
            // flash has shifted out its first data bit.
            if (fall_tick && bit_cnt_q == 6'(HDR_BITS)) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (rise_tick) begin
               rx_d     = {rx_q[6:0], flash_io1};
               rx_cnt_d = rx_cnt_q + 4'd1;
            end
            if (last_full) begin
               csb_d = 1'b1;
            end
            if (rem_q == '0 && !valid_q) begin
               state_d  = CSWAIT;
               cs_cnt_d = '0;
            end
         end
         CSWAIT: begin
            if (cs_cnt_q == CSW'(CS_IDLE - 1)) begin
               state_d = DONE;
            end else begin
               cs_cnt_d = cs_cnt_q + 1'b1;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Output stage: a consumed byte clears valid, but a byte completing in
      // the same cycle replaces it and keeps valid high.
      if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end
      if (byte_full && (!valid_q || data_ready)) begin
         data_d   = rx_q;
         valid_d  = 1'b1;
         rx_cnt_d = '0;
         rem_d    = rem_q - 1'b1;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         tx_q      <= '0;
         bit_cnt_q <= '0;
         rx_q      <= '0;
         rx_cnt_q  <= '0;
         rem_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         csb_q     <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cs_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         bit_cnt_q <= bit_cnt_d;
         rx_q      <= rx_d;
         rx_cnt_q  <= rx_cnt_d;
         rem_q     <= rem_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         csb_q     <= csb_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cs_cnt_q  <= cs_cnt_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign data_o     = data_q;
   assign data_valid = valid_q;
   assign flash_csb  = csb_q;
   assign flash_clk  = sck;
   assign flash_io0  = tx_q[HDR_BITS-1];

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader with a behavioural SPI flash whose
// byte at address a is a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A.
module tb_spi_flash_reader;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        start = 1'b0;
   logic [23:0] addr = '0;
   logic [15:0] len = '0;
   logic        data_ready = 1'b1;
   logic        flash_io1 = 1'b0;
   logic        busy, done, data_valid, flash_csb, flash_clk, flash_io0;
   logic [7:0]  data_o;

   always #5 wb_clk_i = ~wb_clk_i;

   spi_flash_reader #(
      .CLK_DIV   (2),
      .LEN_WIDTH (16),
      .CS_IDLE   (4)
   ) dut (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_i   (wb_rst_i),
      .start      (start),
      .addr       (addr),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .data_o     (data_o),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .flash_csb  (flash_csb),
      .flash_clk  (flash_clk),
      .flash_io0  (flash_io0),
      .flash_io1  (flash_io1)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] flash_byte(input logic [23:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
   endfunction

   // Monitor and flash model, both evaluated on the falling system edge.
   int          cyc = 0;
   int          n_rise = 0;
   int          csb_falls = 0;
   int          done_cnt = 0;
   int          dv_samples = 0;
   int          first_rise_cyc = 0, rise2_cyc = 0, rise40_cyc = 0;
   int          dv_first_cyc = -1, csb_fall_cyc = 0;
   int          hi_run = 0, hi_run_at_done = 0;
   int          start_cyc = 0, done_cyc = 0;
   int          fm_bits = 0;
   logic [31:0] fm_sh = '0;
   logic        prev_sck = 1'b0, prev_csb = 1'b1, prev_dv = 1'b0;
   logic [7:0]  got_q[$];

   always @(negedge wb_clk_i) begin : monitor
      logic [7:0] b;
      int         k;
      cyc++;
      if (start) start_cyc = cyc;
      if (!flash_csb && prev_csb) begin
         fm_bits      = 0;
         n_rise       = 0;
         csb_falls++;
         csb_fall_cyc = cyc;
         dv_first_cyc = -1;
      end
      if (!flash_csb) begin
         if (flash_clk && !prev_sck) begin
            if (fm_bits < 32) fm_sh = {fm_sh[30:0], flash_io0};
            fm_bits++;
            n_rise++;
            if (n_rise == 1)  first_rise_cyc = cyc;
            if (n_rise == 2)  rise2_cyc = cyc;
            if (n_rise == 40) rise40_cyc = cyc;
         end else if (!flash_clk && prev_sck && fm_bits >= 32) begin
            k = fm_bits - 32;
            b = flash_byte(fm_sh[23:0] + 24'(k / 8));
            flash_io1 = b[7 - (k % 8)];
         end
      end
      hi_run = flash_csb ? hi_run + 1 : 0;
      if (data_valid) dv_samples++;
      if (data_valid && !prev_dv && dv_first_cyc < 0) dv_first_cyc = cyc;
      if (data_valid && data_ready) got_q.push_back(data_o);
      if (done) begin
         done_cnt++;
         done_cyc       = cyc;
         hi_run_at_done = hi_run;
      end
      prev_sck = flash_clk;
      prev_csb = flash_csb;
      prev_dv  = data_valid;
   end

   task automatic do_start(input logic [23:0] a, input logic [15:0] n);
      @(posedge wb_clk_i);
      #1;
      start = 1'b1;
      addr  = a;
      len   = n;
      @(posedge wb_clk_i);
      #1;
      start = 1'b0;
      @(negedge wb_clk_i);
      #1;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge wb_clk_i);
         #1;
         n++;
      end
      check("done_seen", 32'(done_cnt != d0), 32'd1);
   endtask

   initial begin
      int base, d0, f0, dv0, n0, bad, n;

      // Reset state
      repeat (3) @(negedge wb_clk_i);
      #1;
      check("rst_csb", flash_csb, 1);
      check("rst_sck", flash_clk, 0);
      check("rst_io0", flash_io0, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", data_valid, 0);
      check("rst_data", data_o, 0);
      @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;

      // Basic read of four bytes with timing checks
      base = got_q.size();
      d0   = done_cnt;
      do_start(24'h000000, 16'd4);
      wait_done(400);
      check("basic_cmd", fm_sh[31:24], 8'h03);
      check("basic_addr", fm_sh[23:0], 24'h000000);
      check("basic_count", got_q.size() - base, 4);
      check("basic_b0", got_q[base + 0], 8'h5A);
      check("basic_b1", got_q[base + 1], 8'h5B);
      check("basic_b2", got_q[base + 2], 8'h58);
      check("basic_b3", got_q[base + 3], 8'h59);
      check("basic_done_cnt", done_cnt - d0, 1);
      check("basic_rises", n_rise, 64);
      check("first_rise_delay", first_rise_cyc - csb_fall_cyc, 2);
      check("sck_period", rise2_cyc - first_rise_cyc, 4);
      check("dv_after_rise40", dv_first_cyc - rise40_cyc, 1);
      check("csb_idle_ge4", 32'(hi_run_at_done >= 4), 1);

      // Backpressure: hold ready low for 50 cycles after the first valid
      @(posedge wb_clk_i);
      #1;
      data_ready = 1'b0;
      base = got_q.size();
      do_start(24'h000100, 16'd3);
      n = 0;
      while (!data_valid && n < 300) begin
         @(negedge wb_clk_i);
         #1;
         n++;
      end
      check("bp_first_valid", data_valid, 1);
      n0  = n_rise;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge wb_clk_i);
         #1;
         if (i >= 40 && (flash_clk || flash_csb)) bad++;
      end
      check("bp_frozen", bad, 0);
      check("bp_rises", n_rise - n0, 8);
      check("bp_hold", data_o, 8'h4B);
      @(posedge wb_clk_i);
      #1;
      data_ready = 1'b1;
      wait_done(300);
      check("bp_count", got_q.size() - base, 3);
      check("bp_b0", got_q[base + 0], 8'h4B);
      check("bp_b1", got_q[base + 1], 8'h4A);
      check("bp_b2", got_q[base + 2], 8'h49);

      // Zero length
      f0  = csb_falls;
      dv0 = dv_samples;
      do_start(24'h000000, 16'd0);
      wait_done(20);
      check("zl_latency", done_cyc - start_cyc, 2);
      check("zl_csb", csb_falls - f0, 0);
      check("zl_valid", dv_samples - dv0, 0);

      // Reset in the middle of the address phase
      base = got_q.size();
      do_start(24'h000100, 16'd2);
      n = 0;
      while (n_rise < 12 && n < 200) begin
         @(negedge wb_clk_i);
         #1;
         n++;
      end
      check("mid_reached", 32'(n_rise >= 12), 1);
      @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i);
      #1;
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      #1;
      check("mid_csb", flash_csb, 1);
      check("mid_sck", flash_clk, 0);
      check("mid_busy", busy, 0);
      check("mid_valid", data_valid, 0);
      check("mid_no_bytes", got_q.size() - base, 0);
      base = got_q.size();
      do_start(24'h000000, 16'd1);
      wait_done(300);
      check("mid_count", got_q.size() - base, 1);
      check("mid_b0", got_q[base], 8'h5A);

      // Start while busy is ignored
      base = got_q.size();
      d0   = done_cnt;
      f0   = csb_falls;
      do_start(24'h000000, 16'd2);
      repeat (10) @(negedge wb_clk_i);
      #1;
      check("busy_high", busy, 1);
      do_start(24'h000200, 16'd1);
      wait_done(300);
      repeat (40) @(negedge wb_clk_i);
      #1;
      check("busy_done_cnt", done_cnt - d0, 1);
      check("busy_csb_falls", csb_falls - f0, 1);
      check("busy_count", got_q.size() - base, 2);
      check("busy_b0", got_q[base + 0], 8'h5A);
      check("busy_b1", got_q[base + 1], 8'h5B);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
